// File: rtl/char_jump_ctl.sv
// Character jump/steer controller: rise/fall gravity model, one position update per movement_tick.
// Optional feature: define CHAR_DOUBLE_JUMP_EN to allow one extra jump per airborne period.
module char_jump_ctl #(
    parameter logic [10:0] X_START     = 11'd400,
    parameter logic [10:0] Y_START     = 11'd500,
    parameter logic [10:0] X_MAX       = 11'd752,
    parameter logic [10:0] Y_MAX       = 11'd568,
    parameter logic [4:0]  V0          = 5'd8,
    parameter logic [4:0]  V_MAX       = 5'd12,
    parameter logic [7:0]  GRAVITY_DIV = 8'd16,
    parameter logic [3:0]  X_STEP      = 4'd2
) (
    input  logic        clk_40MHz,
    input  logic        rst,
    input  logic        movement_tick,
    input  logic        jump_req,
    input  logic        dir_right,
    input  logic        ground_hit,
    output logic        jump_ack,
    output logic        airborne,
    output logic [10:0] xpos,
    output logic [10:0] ypos
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  vel;
    logic [7:0]  grav_cnt;
    logic        pending;
`ifdef CHAR_DOUBLE_JUMP_EN
    logic        dj_used;
`endif

    logic [11:0] x_right, x_left, y_up, y_down;
    logic [10:0] x_air, y_rise;
    logic [4:0]  vel_up;
    logic        grav_wrap, land_floor, launch_req, air_launch;

    // 12-bit arithmetic exposes under/overflow (bit 11) before clamping.
    always_comb begin
        // NOTE: every combinational output is assigned on every path, so no latches are inferred.
        x_right    = 12'(xpos) + 12'(X_STEP);
        x_left     = 12'(xpos) - 12'(X_STEP);
        y_up       = 12'(ypos) - 12'(vel);
        y_down     = 12'(ypos) + 12'(vel);
        if (dir_right)
            x_air = (x_right > 12'(X_MAX)) ? X_MAX : x_right[10:0];
        else
            x_air = x_left[11] ? 11'd0 : x_left[10:0];
        y_rise     = y_up[11] ? 11'd0 : y_up[10:0];
        land_floor = (y_down >= 12'(Y_MAX));
        grav_wrap  = (grav_cnt == GRAVITY_DIV - 8'd1);
        vel_up     = (vel >= V_MAX) ? V_MAX : vel + 5'd1;
        launch_req = pending | jump_req;
`ifdef CHAR_DOUBLE_JUMP_EN
        air_launch = launch_req & ~dj_used;
`else
        air_launch = 1'b0;
`endif
    end

    always_ff @(posedge clk_40MHz) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
        if (rst) begin
            state    <= IDLE;
            xpos     <= X_START;
            ypos     <= Y_START;
            vel      <= 5'd0;
            grav_cnt <= 8'd0;
            pending  <= 1'b0;
            jump_ack <= 1'b0;
            airborne <= 1'b0;
`ifdef CHAR_DOUBLE_JUMP_EN
            dj_used  <= 1'b0;
`endif
        end else begin
            jump_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (movement_tick && launch_req) begin
                        vel      <= V0;
                        grav_cnt <= 8'd0;
                        pending  <= 1'b0;
                        state    <= RISE;
                        airborne <= 1'b1;
                        jump_ack <= 1'b1;
                    end else if (jump_req) begin
                        pending  <= 1'b1;
                    end
                end
                default: begin
`ifdef CHAR_DOUBLE_JUMP_EN
                    if (jump_req && !dj_used)
                        pending <= 1'b1;
`else
                    pending <= 1'b0;
`endif
                    if (movement_tick) begin
                        if (air_launch) begin
                            // Mid-air relaunch replaces this tick's motion, like a ground launch.
                            vel      <= V0;
                            grav_cnt <= 8'd0;
                            pending  <= 1'b0;
                            state    <= RISE;
                            jump_ack <= 1'b1;
`ifdef CHAR_DOUBLE_JUMP_EN
                            dj_used  <= 1'b1;
`endif
                        end else begin
                            xpos     <= x_air;
                            grav_cnt <= grav_wrap ? 8'd0 : grav_cnt + 8'd1;
                            if (state == RISE) begin
                                ypos <= y_rise;
                                if (grav_wrap) begin
                                    if (vel <= 5'd1) begin
                                        vel   <= 5'd0;
                                        state <= FALL;
                                    end else begin
                                        vel   <= vel - 5'd1;
                                    end
                                end
                            end else if (ground_hit || land_floor) begin
                                // A platform hit holds ypos; reaching the floor snaps to it.
                                if (!ground_hit)
                                    ypos <= Y_MAX;
                                vel      <= 5'd0;
                                state    <= IDLE;
                                airborne <= 1'b0;
`ifdef CHAR_DOUBLE_JUMP_EN
                                dj_used  <= 1'b0;
`endif
                            end else begin
                                ypos <= y_down[10:0];
                                if (grav_wrap)
                                    vel <= vel_up;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
